// File: rtl/lab_access_scheduler.sv
// Shared card-reader scheduler for the Digital and Mera labs: round-robin grant of two
// gate requests, occupancy/restriction decision and a timed unlock window per lab door.
module lab_access_scheduler #(
   parameter int CAP         = 30,
   parameter int RESTRICT    = 15,
   parameter int DOOR_CYCLES = 3
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [1:0] req_valid,
   output logic [1:0] req_ready,
   input  logic [9:0] req_code,
   input  logic [1:0] req_lab,
   input  logic [3:0] req_mode,
   output logic       rsp_valid,
   output logic       rsp_id,
   output logic [2:0] rsp_status,
   output logic [5:0] cnt_digital,
   output logic [5:0] cnt_mera,
   output logic       full_digital,
   output logic       full_mera,
   output logic       empty_digital,
   output logic       empty_mera,
   output logic       unlock_digital,
   output logic       unlock_mera,
   output logic       warn_digital,
   output logic       warn_mera
);

   localparam int TW = $clog2(DOOR_CYCLES + 1);
   localparam logic [5:0]    CNT_CAP      = 6'(CAP);
   localparam logic [5:0]    CNT_RESTRICT = 6'(RESTRICT);
   localparam logic [TW-1:0] TIMER_LOAD   = TW'(DOOR_CYCLES);
   localparam logic [TW-1:0] TIMER_LAST   = TW'(1);

   localparam logic [2:0] ST_ADMIT    = 3'b000;
   localparam logic [2:0] ST_EXIT     = 3'b001;
   localparam logic [2:0] ST_RESTRICT = 3'b010;
   localparam logic [2:0] ST_FULL     = 3'b011;
   localparam logic [2:0] ST_EMPTY    = 3'b100;
   localparam logic [2:0] ST_NOP      = 3'b101;

   typedef enum logic {IDLE = 1'b0, OPEN = 1'b1} door_state_t;

   // Digital admits odd-parity cards above the restriction level, Mera admits even parity.
   function automatic logic code_parity(input logic [4:0] code);
      return ^code;
   endfunction

   door_state_t     door_state_r [2];
   door_state_t     door_state_s [2];
   logic [TW-1:0]   door_timer_r [2];
   logic [TW-1:0]   door_timer_s [2];

   logic       ptr_r;
   logic [1:0] eligible_s;
   logic       grant_s;
   logic       sel_s;
   logic       sel_lab_s;
   logic [4:0] sel_code_s;
   logic [1:0] sel_mode_s;
   logic [5:0] sel_cnt_s;
   logic [2:0] status_s;
   logic       inc_s;
   logic       dec_s;
   logic       warn_s;
   logic       opens_s;

   // Eligibility and round-robin selection of a single winner.
   always_comb begin
      eligible_s = 2'b00;
      grant_s    = 1'b0;
      sel_s      = ptr_r;
      for (int i = 0; i < 2; i++) begin
         eligible_s[i] = req_valid[i] && (door_state_r[req_lab[i]] == IDLE);
      end
      if (eligible_s[ptr_r]) begin
         grant_s = 1'b1;
         sel_s   = ptr_r;
      end else if (eligible_s[~ptr_r]) begin
         grant_s = 1'b1;
         sel_s   = ~ptr_r;
      end else begin
         grant_s = 1'b0;
         sel_s   = ptr_r;
      end
      if (grant_s) begin
         req_ready = sel_s ? 2'b10 : 2'b01;
      end else begin
         req_ready = 2'b00;
      end
   end

   // Occupancy/restriction decision for the selected request.
   always_comb begin
      sel_lab_s  = req_lab[sel_s];
      sel_code_s = sel_s ? req_code[9:5] : req_code[4:0];
      sel_mode_s = sel_s ? req_mode[3:2] : req_mode[1:0];
      sel_cnt_s  = sel_lab_s ? cnt_mera : cnt_digital;
      status_s   = ST_NOP;
      inc_s      = 1'b0;
      dec_s      = 1'b0;
      warn_s     = 1'b0;
      case (sel_mode_s)
         2'b00: begin
            if (sel_cnt_s == 6'd0) begin
               status_s = ST_EMPTY;
            end else begin
               status_s = ST_EXIT;
               dec_s    = 1'b1;
            end
         end
         2'b01: begin
            if (sel_cnt_s >= CNT_CAP) begin
               status_s = ST_FULL;
            end else if (sel_cnt_s < CNT_RESTRICT) begin
               status_s = ST_ADMIT;
               inc_s    = 1'b1;
            end else if (code_parity(sel_code_s) != sel_lab_s) begin
               status_s = ST_ADMIT;
               inc_s    = 1'b1;
            end else begin
               status_s = ST_RESTRICT;
               warn_s   = 1'b1;
            end
         end
         default: begin
            status_s = ST_NOP;
         end
      endcase
      opens_s = inc_s || dec_s;
   end

   // Arbitration pointer and registered response.
   always_ff @(posedge CLK) begin
      if (RST) begin
         ptr_r        <= 1'b0;
         rsp_valid    <= 1'b0;
         rsp_id       <= 1'b0;
         rsp_status   <= 3'b000;
         warn_digital <= 1'b0;
         warn_mera    <= 1'b0;
      end else begin
         rsp_valid    <= grant_s;
         warn_digital <= grant_s && warn_s && !sel_lab_s;
         warn_mera    <= grant_s && warn_s && sel_lab_s;
         if (grant_s) begin
            ptr_r      <= ~sel_s;
            rsp_id     <= sel_s;
            rsp_status <= status_s;
         end
      end
   end

   // Occupancy counters, bounded to 0..CAP by the decision logic.
   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_digital <= 6'd0;
         cnt_mera    <= 6'd0;
      end else if (grant_s && !sel_lab_s) begin
         if (inc_s) begin
            cnt_digital <= cnt_digital + 6'd1;
         end else if (dec_s) begin
            cnt_digital <= cnt_digital - 6'd1;
         end
      end else if (grant_s && sel_lab_s) begin
         if (inc_s) begin
            cnt_mera <= cnt_mera + 6'd1;
         end else if (dec_s) begin
            cnt_mera <= cnt_mera - 6'd1;
         end
      end
   end

   // Door FSM next state: open for DOOR_CYCLES cycles after a successful admit/exit.
   always_comb begin
      for (int l = 0; l < 2; l++) begin
         door_state_s[l] = door_state_r[l];
         door_timer_s[l] = door_timer_r[l];
         case (door_state_r[l])
            IDLE: begin
               if (grant_s && opens_s && (sel_lab_s == 1'(l))) begin
                  door_state_s[l] = OPEN;
                  door_timer_s[l] = TIMER_LOAD;
               end else begin
                  door_state_s[l] = IDLE;
               end
            end
            OPEN: begin
               if (door_timer_r[l] <= TIMER_LAST) begin
                  door_state_s[l] = IDLE;
                  door_timer_s[l] = '0;
               end else begin
                  door_timer_s[l] = door_timer_r[l] - TIMER_LAST;
               end
            end
            default: begin
               door_state_s[l] = IDLE;
               door_timer_s[l] = '0;
            end
         endcase
      end
   end

   // Door FSM state registers.
   always_ff @(posedge CLK) begin
      for (int l = 0; l < 2; l++) begin
         if (RST) begin
            door_state_r[l] <= IDLE;
            door_timer_r[l] <= '0;
         end else begin
            door_state_r[l] <= door_state_s[l];
            door_timer_r[l] <= door_timer_s[l];
         end
      end
   end

   assign unlock_digital = (door_state_r[0] == OPEN);
   assign unlock_mera    = (door_state_r[1] == OPEN);
   assign full_digital   = (cnt_digital == CNT_CAP);
   assign full_mera      = (cnt_mera == CNT_CAP);
   assign empty_digital  = (cnt_digital == 6'd0);
   assign empty_mera     = (cnt_mera == 6'd0);

endmodule

// File: tb/tb_lab_access_scheduler.sv
// Directed self-checking bench for lab_access_scheduler (CAP=30, RESTRICT=15, DOOR_CYCLES=3).
module tb_lab_access_scheduler;

   logic       CLK = 1'b0;
   logic       RST;
   logic [1:0] req_valid;
   logic [1:0] req_ready;
   logic [9:0] req_code;
   logic [1:0] req_lab;
   logic [3:0] req_mode;
   logic       rsp_valid;
   logic       rsp_id;
   logic [2:0] rsp_status;
   logic [5:0] cnt_digital;
   logic [5:0] cnt_mera;
   logic       full_digital, full_mera, empty_digital, empty_mera;
   logic       unlock_digital, unlock_mera, warn_digital, warn_mera;

   int checks   = 0;
   int failures = 0;

   lab_access_scheduler dut (
      .CLK(CLK), .RST(RST),
      .req_valid(req_valid), .req_ready(req_ready), .req_code(req_code),
      .req_lab(req_lab), .req_mode(req_mode),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_status(rsp_status),
      .cnt_digital(cnt_digital), .cnt_mera(cnt_mera),
      .full_digital(full_digital), .full_mera(full_mera),
      .empty_digital(empty_digital), .empty_mera(empty_mera),
      .unlock_digital(unlock_digital), .unlock_mera(unlock_mera),
      .warn_digital(warn_digital), .warn_mera(warn_mera)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   task automatic apply_reset;
      RST       = 1'b1;
      req_valid = 2'b00;
      @(posedge CLK);
      #1;
      RST = 1'b0;
   endtask

   // Present one request and hold it until accepted; returns just after the accepting edge.
   task automatic issue(input int id, input logic [4:0] code, input logic lab,
                        input logic [1:0] mode, output int waited);
      waited = 0;
      @(negedge CLK);
      req_valid[id]         = 1'b1;
      req_code[id*5 +: 5]   = code;
      req_lab[id]           = lab;
      req_mode[id*2 +: 2]   = mode;
      #1;
      while (!req_ready[id] && waited < 50) begin
         @(negedge CLK);
         #1;
         waited++;
      end
      checks++;
      if (waited >= 50) begin
         failures++;
         $display("FAIL issue_timeout got=no_ready exp=ready id=%0d", id);
      end
      @(posedge CLK);
      #1;
      req_valid[id] = 1'b0;
   endtask

   task automatic test_reset;
      RST = 1'b1; req_valid = 2'b00; req_code = 10'd0; req_lab = 2'b00; req_mode = 4'b1111;
      @(posedge CLK); @(posedge CLK); #1;
      checks++; if (cnt_digital !== 6'd0) begin failures++; $display("FAIL rst_cnt_d got=%0d exp=0", cnt_digital); end
      checks++; if (cnt_mera !== 6'd0) begin failures++; $display("FAIL rst_cnt_m got=%0d exp=0", cnt_mera); end
      checks++; if ({empty_digital, empty_mera, full_digital, full_mera} !== 4'b1100) begin failures++; $display("FAIL rst_flags got=%b exp=1100", {empty_digital, empty_mera, full_digital, full_mera}); end
      checks++; if ({unlock_digital, unlock_mera, rsp_valid, rsp_id, warn_digital, warn_mera} !== 6'b000000) begin failures++; $display("FAIL rst_outs got=%b exp=000000", {unlock_digital, unlock_mera, rsp_valid, rsp_id, warn_digital, warn_mera}); end
      checks++; if (rsp_status !== 3'b000) begin failures++; $display("FAIL rst_status got=%b exp=000", rsp_status); end
      RST = 1'b0;
   endtask

   task automatic test_first_admit;
      int w;
      apply_reset();
      issue(0, 5'b00001, 1'b0, 2'b01, w);
      checks++; if (w !== 0) begin failures++; $display("FAIL adm_latency got=%0d exp=0", w); end
      checks++; if ({rsp_valid, rsp_id, rsp_status} !== 5'b10000) begin failures++; $display("FAIL adm_rsp got=%b exp=10000", {rsp_valid, rsp_id, rsp_status}); end
      checks++; if (cnt_digital !== 6'd1 || empty_digital !== 1'b0) begin failures++; $display("FAIL adm_cnt got=%0d/%b exp=1/0", cnt_digital, empty_digital); end
      checks++; if (unlock_digital !== 1'b1) begin failures++; $display("FAIL adm_unlock0 got=%b exp=1", unlock_digital); end
      for (int k = 1; k <= 3; k++) begin
         @(posedge CLK); #1;
         checks++; if (unlock_digital !== (k < 3)) begin failures++; $display("FAIL adm_unlock%0d got=%b exp=%b", k, unlock_digital, (k < 3)); end
         if (k == 1) begin
            checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL adm_pulse got=%b exp=0", rsp_valid); end
         end
      end
   endtask

   task automatic test_restrict;
      int w;
      apply_reset();
      for (int n = 0; n < 15; n++) issue(0, 5'b00011, 1'b1, 2'b01, w);
      checks++; if (cnt_mera !== 6'd15) begin failures++; $display("FAIL rst_preload got=%0d exp=15", cnt_mera); end
      issue(0, 5'b00001, 1'b1, 2'b01, w);
      checks++; if (rsp_status !== 3'b010 || rsp_valid !== 1'b1) begin failures++; $display("FAIL restr_status got=%b exp=010", rsp_status); end
      checks++; if ({warn_mera, warn_digital} !== 2'b10) begin failures++; $display("FAIL restr_warn got=%b exp=10", {warn_mera, warn_digital}); end
      checks++; if (cnt_mera !== 6'd15 || unlock_mera !== 1'b0) begin failures++; $display("FAIL restr_cnt got=%0d/%b exp=15/0", cnt_mera, unlock_mera); end
      @(posedge CLK); #1;
      checks++; if ({warn_mera, unlock_mera} !== 2'b00) begin failures++; $display("FAIL restr_after got=%b exp=00", {warn_mera, unlock_mera}); end
      issue(0, 5'b00011, 1'b1, 2'b01, w);
      checks++; if (rsp_status !== 3'b000 || cnt_mera !== 6'd16 || warn_mera !== 1'b0) begin failures++; $display("FAIL restr_admit got=%b/%0d exp=000/16", rsp_status, cnt_mera); end
   endtask

   task automatic test_back_to_back;
      logic [1:0] exp_ready;
      apply_reset();
      @(negedge CLK);
      req_valid = 2'b11; req_lab = 2'b00; req_mode = 4'b0101; req_code = 10'd0;
      for (int k = 0; k <= 12; k++) begin
         #1;
         exp_ready = (k % 4 != 0) ? 2'b00 : (((k / 4) % 2 == 1) ? 2'b10 : 2'b01);
         checks++; if (req_ready !== exp_ready) begin failures++; $display("FAIL b2b_ready%0d got=%b exp=%b", k, req_ready, exp_ready); end
         @(posedge CLK); #1;
         if (k % 4 == 0) begin
            checks++; if ({rsp_valid, rsp_id, rsp_status} !== {1'b1, 1'((k / 4) % 2), 3'b000}) begin failures++; $display("FAIL b2b_rsp%0d got=%b exp=%b", k, {rsp_valid, rsp_id, rsp_status}, {1'b1, 1'((k / 4) % 2), 3'b000}); end
            checks++; if (cnt_digital !== 6'(k / 4 + 1)) begin failures++; $display("FAIL b2b_cnt%0d got=%0d exp=%0d", k, cnt_digital, k / 4 + 1); end
         end
         @(negedge CLK);
      end
      req_valid = 2'b00;
   endtask

   task automatic test_full_empty;
      int w;
      apply_reset();
      for (int n = 0; n < 30; n++) issue(0, 5'b00001, 1'b0, 2'b01, w);
      checks++; if (cnt_digital !== 6'd30 || full_digital !== 1'b1 || full_mera !== 1'b0) begin failures++; $display("FAIL full_fill got=%0d/%b exp=30/1", cnt_digital, full_digital); end
      issue(1, 5'b00001, 1'b0, 2'b01, w);
      checks++; if ({rsp_id, rsp_status} !== 4'b1011 || cnt_digital !== 6'd30 || unlock_digital !== 1'b0) begin failures++; $display("FAIL full_reject got=%b/%0d exp=1011/30", {rsp_id, rsp_status}, cnt_digital); end
      issue(0, 5'b00001, 1'b0, 2'b00, w);
      checks++; if (rsp_status !== 3'b001 || cnt_digital !== 6'd29 || full_digital !== 1'b0) begin failures++; $display("FAIL full_exit got=%b/%0d exp=001/29", rsp_status, cnt_digital); end
      issue(0, 5'b00000, 1'b0, 2'b01, w);
      checks++; if (rsp_status !== 3'b010 || warn_digital !== 1'b1 || cnt_digital !== 6'd29) begin failures++; $display("FAIL dig_restr got=%b/%b exp=010/1", rsp_status, warn_digital); end
      issue(1, 5'b00000, 1'b1, 2'b00, w);
      checks++; if (rsp_status !== 3'b100 || cnt_mera !== 6'd0 || empty_mera !== 1'b1 || unlock_mera !== 1'b0) begin failures++; $display("FAIL empty_reject got=%b/%0d exp=100/0", rsp_status, cnt_mera); end
      issue(0, 5'b00000, 1'b1, 2'b11, w);
      checks++; if ({rsp_valid, rsp_status} !== 4'b1101 || cnt_mera !== 6'd0 || cnt_digital !== 6'd29) begin failures++; $display("FAIL nop got=%b exp=1101", {rsp_valid, rsp_status}); end
   endtask

   task automatic test_blocked_lab;
      int w;
      apply_reset();
      issue(1, 5'b00000, 1'b0, 2'b01, w);
      req_valid = 2'b11; req_lab = 2'b10; req_mode = 4'b0101; req_code = 10'd0;
      #1;
      checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL blk_first got=%b exp=10", req_ready); end
      @(posedge CLK); #1;
      req_valid[1] = 1'b0;
      checks++; if ({rsp_id, rsp_status} !== 4'b1000 || cnt_mera !== 6'd1) begin failures++; $display("FAIL blk_rsp1 got=%b/%0d exp=1000/1", {rsp_id, rsp_status}, cnt_mera); end
      for (int k = 0; k < 3; k++) begin
         checks++; if (req_ready !== ((k == 2) ? 2'b01 : 2'b00)) begin failures++; $display("FAIL blk_wait%0d got=%b exp=%b", k, req_ready, ((k == 2) ? 2'b01 : 2'b00)); end
         @(posedge CLK); #1;
      end
      req_valid[0] = 1'b0;
      checks++; if ({rsp_valid, rsp_id, rsp_status} !== 5'b10000 || cnt_digital !== 6'd2) begin failures++; $display("FAIL blk_rsp0 got=%b/%0d exp=10000/2", {rsp_valid, rsp_id, rsp_status}, cnt_digital); end
   endtask

   task automatic test_reset_mid_open;
      int w;
      apply_reset();
      for (int n = 0; n < 5; n++) issue(0, 5'b00001, 1'b0, 2'b01, w);
      checks++; if (cnt_digital !== 6'd5 || unlock_digital !== 1'b1) begin failures++; $display("FAIL mid_pre got=%0d/%b exp=5/1", cnt_digital, unlock_digital); end
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      checks++; if ({unlock_digital, rsp_valid, empty_digital} !== 3'b001 || cnt_digital !== 6'd0) begin failures++; $display("FAIL mid_reset got=%b/%0d exp=001/0", {unlock_digital, rsp_valid, empty_digital}, cnt_digital); end
      req_valid = 2'b11; req_lab = 2'b10; req_mode = 4'b0101;
      #1;
      checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL mid_ptr got=%b exp=01", req_ready); end
      req_valid = 2'b00;
   endtask

   initial begin
      test_reset();
      test_first_admit();
      test_restrict();
      test_back_to_back();
      test_full_empty();
      test_blocked_lab();
      test_reset_mid_open();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
